// File: rtl/div_request_sequencer.sv
// Request FIFO and single-outstanding issue controller for the Q4.4 Goldschmidt divider.
// Zero denominators are answered locally, and a hung divider is cut off by a timeout.
module div_request_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_num,
  input  logic [7:0]             in_den,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   div_start,
  output logic [7:0]             div_num,
  output logic [7:0]             div_den,
  input  logic [7:0]             div_quot,
  input  logic                   div_valid,
  input  logic                   div_error,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_quot,
  output logic                   out_error,
  output logic                   out_timeout,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [7:0]       num;
    logic [7:0]       den;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  req_t             mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  req_t             head;
  state_t           state;
  logic [TW-1:0]    tmo_cnt;
  logic [TAG_W-1:0] cur_tag;
  logic             push, pop;

  assign head       = mem[rd_ptr];
  assign in_ready   = (count < CW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign pop        = (state == IDLE) && (count != '0);
  assign busy       = (state != IDLE) || (count != '0);
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{num: in_num, den: in_den, tag: in_tag};
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      cur_tag     <= '0;
      div_start   <= 1'b0;
      div_num     <= '0;
      div_den     <= '0;
      out_valid   <= 1'b0;
      out_quot    <= '0;
      out_error   <= 1'b0;
      out_timeout <= 1'b0;
      out_tag     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            if (head.den == 8'h00) begin
              // Saturate toward the sign of the numerator; divider stays idle.
              out_quot    <= head.num[7] ? 8'h80 : 8'h7F;
              out_error   <= 1'b1;
              out_timeout <= 1'b0;
              out_tag     <= head.tag;
              out_valid   <= 1'b1;
              state       <= RESP;
            end else begin
              div_num   <= head.num;
              div_den   <= head.den;
              cur_tag   <= head.tag;
              div_start <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          div_start <= 1'b0;
          tmo_cnt   <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // First WAIT cycle (tmo_cnt==0) may still see the previous op's valid.
          if (tmo_cnt != '0 && div_valid) begin
            out_quot    <= div_quot;
            out_error   <= div_error;
            out_timeout <= 1'b0;
            out_tag     <= cur_tag;
            out_valid   <= 1'b1;
            state       <= RESP;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            out_quot    <= 8'h00;
            out_error   <= 1'b1;
            out_timeout <= 1'b1;
            out_tag     <= cur_tag;
            out_valid   <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
